// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, runs the imem request/grant/response
// handshake and holds one fetched instruction for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic [24:0] imm_field,
    input  logic        redirect,
    input  logic        redirect_jalr,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imm_ext,
    input  logic [31:0] jalr_target,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_misaligned;

    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_capture;
    logic        w_advance;

    assign w_target_raw = redirect_jalr ? (jalr_target & ~32'h1) : (redirect_pc + imm_ext);
    assign w_target     = w_target_raw & ~32'h3;

    // r_run keeps imem_req low for the first cycle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_REQ;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (redirect)
                    w_state_next = S_REQ;
                else if (imem_gnt && r_run)
                    w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect && imem_rvalid)
                    w_state_next = S_REQ;
                else if (redirect)
                    w_state_next = S_FLUSH;
                else if (imem_rvalid)
                    w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (redirect || instr_ready)
                    w_state_next = S_REQ;
            end
            S_FLUSH: begin
                if (redirect)
                    w_state_next = S_FLUSH;
                else if (imem_rvalid)
                    w_state_next = S_REQ;
            end
            default: w_state_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == S_REQ) && r_run;
        instr_valid = (r_state == S_HOLD);
        w_capture   = (r_state == S_WAIT) && imem_rvalid && !redirect;
        w_advance   = (r_state == S_HOLD) && instr_ready && !redirect;
    end

    // Redirect outranks every other PC update, including consumption by decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_instr      <= NOP;
            r_instr_pc   <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= redirect && w_target_raw[1];
            if (redirect)
                r_pc <= w_target;
            else if (w_advance)
                r_pc <= r_pc + 32'd4;
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign imem_addr      = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign instr_pc_plus4 = r_instr_pc + 32'd4;
    assign imm_field      = r_instr[31:7];
    assign misaligned     = r_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reactive memory, flag-level fetch model,
// per-cycle comparison plus directed literal checks.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [24:0] imm_field;
    logic        redirect;
    logic        redirect_jalr;
    logic [31:0] redirect_pc;
    logic [31:0] imm_ext;
    logic [31:0] jalr_target;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .imm_field      (imm_field),
        .redirect       (redirect),
        .redirect_jalr  (redirect_jalr),
        .redirect_pc    (redirect_pc),
        .imm_ext        (imm_ext),
        .jalr_target    (jalr_target),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a[31:4] == 28'h0) ? 32'h0050_0093 : (a ^ 32'hA5A5_0013);
    endfunction

    // ---------------- memory responder ----------------
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          rv_delay = 0;
    logic [31:0] grants[$];

    // Drives gnt/rvalid for the coming clock edge; never grants alongside a redirect.
    task automatic mem_drive();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (imem_req && !redirect && reset) begin
            imem_gnt = 1'b1;
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = rv_delay;
            grants.push_back(imem_addr);
        end
    endtask

    task automatic tick();
        mem_drive();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim);
        for (int i = 0; i < lim && !instr_valid; i++)
            tick();
        total++;
        if (!instr_valid) begin
            bad++;
            $display("FAIL wait_valid: instr_valid still 0 after %0d cycles, want 1", lim);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_started, m_busy, m_drop, m_have, m_mis;
    logic [31:0] m_pc, m_instr, m_ipc;
    logic [31:0] m_tgt;
    logic        m_req;

    assign m_tgt = redirect_jalr ? (jalr_target & 32'hFFFF_FFFE) : (redirect_pc + imm_ext);
    assign m_req = m_started && !m_busy && !m_have && !m_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_started <= 1'b0;
            m_busy    <= 1'b0;
            m_drop    <= 1'b0;
            m_have    <= 1'b0;
            m_mis     <= 1'b0;
            m_pc      <= 32'h0;
            m_instr   <= 32'h0000_0013;
            m_ipc     <= 32'h0;
        end else begin
            m_started <= 1'b1;
            m_mis     <= redirect && m_tgt[1];
            if (redirect) begin
                m_pc <= m_tgt & 32'hFFFF_FFFC;
                if (m_have) begin
                    m_have <= 1'b0;
                end else if (m_busy) begin
                    m_busy <= 1'b0;
                    m_drop <= !imem_rvalid;
                end
            end else if (m_have) begin
                if (instr_ready) begin
                    m_have <= 1'b0;
                    m_pc   <= m_pc + 32'd4;
                end
            end else if (m_busy) begin
                if (imem_rvalid) begin
                    m_have  <= 1'b1;
                    m_busy  <= 1'b0;
                    m_instr <= imem_rdata;
                    m_ipc   <= m_pc;
                end
            end else if (m_drop) begin
                if (imem_rvalid)
                    m_drop <= 1'b0;
            end else if (m_req && imem_gnt) begin
                m_busy <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("req",        {31'd0, imem_req},    {31'd0, m_req});
        chk("addr",       imem_addr,            m_pc);
        chk("valid",      {31'd0, instr_valid}, {31'd0, m_have});
        chk("instr",      instr,                m_instr);
        chk("instr_pc",   instr_pc,             m_ipc);
        chk("pc_plus4",   instr_pc_plus4,       m_ipc + 32'd4);
        chk("imm_field",  {7'd0, imm_field},    {7'd0, m_instr[31:7]});
        chk("misaligned", {31'd0, misaligned},  {31'd0, m_mis});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int vcount;
        reset         = 1'b0;
        redirect      = 1'b0;
        redirect_jalr = 1'b0;
        redirect_pc   = '0;
        imm_ext       = '0;
        jalr_target   = '0;
        instr_ready   = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'h0000_0013);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_plus4", instr_pc_plus4,       32'h4);
        chk("rst_imm",   {7'd0, imm_field},    32'h0);

        // Reset release, 0-wait memory, decode always ready
        reset       = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("start_req", {31'd0, imem_req}, 32'd1);
        vcount = 0;
        for (int i = 0; i < 9; i++) begin
            if (instr_valid) begin
                vcount++;
                chk("stream_imm", {7'd0, imm_field}, 32'h0000_A001);
            end
            tick();
        end
        chk("stream_vcount", vcount, 32'd3);
        if (grants.size() < 3) begin
            chk("stream_grants", grants.size(), 32'd3);
        end else begin
            chk("grant0", grants[0], 32'h0);
            chk("grant1", grants[1], 32'h4);
            chk("grant2", grants[2], 32'h8);
        end

        // Backpressure in HOLD
        instr_ready = 1'b0;
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_instr", instr,                32'h0050_0093);
            chk("bp_pc",    instr_pc,             32'hC);
            chk("bp_imm",   {7'd0, imm_field},    32'h0000_A001);
            chk("bp_req",   {31'd0, imem_req},    32'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp_next_addr", imem_addr, 32'h10);

        // Branch redirect in HOLD beats instr_ready
        wait_valid(10);
        chk("br_held_instr", instr, 32'hA5A5_0003);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        imm_ext     = 32'hFFFF_FFF0;
        instr_ready = 1'b1;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("br_addr",  imem_addr,            32'h0F0);
        chk("br_valid", {31'd0, instr_valid}, 32'd0);
        chk("br_req",   {31'd0, imem_req},    32'd1);

        // Redirect while WAITing on a slow response
        rv_delay = 3;
        tick();
        redirect      = 1'b1;
        redirect_jalr = 1'b1;
        jalr_target   = 32'h300;
        tick();
        redirect      = 1'b0;
        redirect_jalr = 1'b0;
        chk("fl_req",  {31'd0, imem_req}, 32'd0);
        chk("fl_addr", imem_addr,         32'h300);
        wait_valid(20);
        chk("fl_pc",    instr_pc, 32'h300);
        chk("fl_instr", instr,    32'hA5A5_0313);
        rv_delay = 0;

        // JALR to a target with bit 1 set, then bit 0 only
        redirect      = 1'b1;
        redirect_jalr = 1'b1;
        jalr_target   = 32'h0000_2003;
        tick();
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_addr",  imem_addr,           32'h2000);
        jalr_target = 32'h0000_2001;
        tick();
        redirect      = 1'b0;
        redirect_jalr = 1'b0;
        chk("odd_nopulse", {31'd0, misaligned}, 32'd0);
        chk("odd_addr",    imem_addr,           32'h2000);

        // PC wrap at the top of the address space
        redirect      = 1'b1;
        redirect_jalr = 1'b1;
        jalr_target   = 32'hFFFF_FFFC;
        tick();
        redirect      = 1'b0;
        redirect_jalr = 1'b0;
        instr_ready   = 1'b1;
        wait_valid(10);
        chk("wrap_pc",    instr_pc,       32'hFFFF_FFFC);
        chk("wrap_plus4", instr_pc_plus4, 32'h0);
        tick();
        instr_ready = 1'b0;
        chk("wrap_addr", imem_addr,         32'h0);
        chk("wrap_req",  {31'd0, imem_req}, 32'd1);

        // Asynchronous reset while a response is outstanding
        tick();
        #2;
        reset    = 1'b0;
        mem_busy = 1'b0;
        #1;
        chk("arst_req",   {31'd0, imem_req},    32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_addr",  imem_addr,            32'h0);
        chk("arst_instr", instr,                32'h0000_0013);
        @(negedge clk);
        #1;
        reset = 1'b1;
        grants.delete();
        instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++)
            tick();
        if (grants.size() < 2) begin
            chk("rf_grants", grants.size(), 32'd2);
        end else begin
            chk("rf_grant0", grants[0], 32'h0);
            chk("rf_grant1", grants[1], 32'h4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the RV32I core. It owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and holds the fetched instruction for decode. It drives the 25-bit immediate field (instr[31:7]) into the immediate extender. It consumes the extender's 32-bit sign-extended immediate to form branch and JAL targets, and takes JALR targets from the ALU.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset (word aligned).
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- imem_req  out  1  read request valid.
- imem_addr  out  32  byte address of the request; always word aligned.
- imem_gnt  in  1  request accepted this cycle (only meaningful while imem_req=1).
- imem_rvalid  in  1  read data valid; at most one response per grant, returned in order.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc/imm_field hold a valid instruction.
- instr_ready  in  1  decode consumes the instruction this cycle.
- instr  out  32  held instruction.
- instr_pc  out  32  PC of the held instruction.
- instr_pc_plus4  out  32  instr_pc + 4.
- imm_field  out  25  instr[31:7], routed to the immediate extender.
- redirect  in  1  take a control transfer this cycle.
- redirect_jalr  in  1  with redirect: target = jalr_target; otherwise target = redirect_pc + imm_ext.
- redirect_pc  in  32  PC of the branching instruction.
- imm_ext  in  32  sign-extended immediate from the extender.
- jalr_target  in  32  ALU result for JALR.
- misaligned  out  1  one-cycle pulse: redirect target had bit 1 set.

## Operation
- Target computation:
  - JALR: target = jalr_target & ~32'h1.
  - Branch/JAL: target = redirect_pc + imm_ext, modulo 2^32 (wraps, no overflow flag).
  - If target[1] = 1: misaligned pulses the next cycle, and the PC loads target & ~32'h3.
- Internal register pc; imem_addr = pc at all times.
- States:
  - REQ: imem_req=1.
  - WAIT: one request outstanding.
  - HOLD: instr_valid=1.
  - FLUSH: outstanding response is discarded on arrival.
- Transitions, in priority order within each state:
  - REQ:
    - redirect → pc<=target, stay in REQ. The address may change only while not yet granted; the grant in the same cycle is ignored and the request re-issues.
    - imem_gnt → WAIT.
  - WAIT:
    - redirect with imem_rvalid → drop data, pc<=target, go to REQ.
    - redirect alone → pc<=target, go to FLUSH.
    - imem_rvalid → instr<=imem_rdata, instr_pc<=pc, go to HOLD.
  - HOLD:
    - redirect → instr_valid<=0, pc<=target, go to REQ. Redirect beats instr_ready; the instruction is not consumed.
    - instr_ready → pc<=pc+4 (wraps at 2^32), go to REQ.
  - FLUSH:
    - redirect → pc<=target, stay in FLUSH.
    - imem_rvalid → discard, go to REQ.
- instr, instr_pc and imm_field are stable while instr_valid=1 and change only on capture.

## Timing
- Reset values, applied asynchronously while reset=0:
  - state=REQ, imem_req=0.
  - pc=imem_addr=RESET_PC.
  - instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4.
  - imm_field=25'h0000_000 (NOP bits [31:7]), misaligned=0.
- imem_req rises in the first clock after reset deasserts. It is 0 throughout reset.
- Reset asserted mid-transaction: the outstanding response is lost, with no flush. Memory is reset by the same signal.
- Latency, gnt and rvalid in the earliest cycles: req (cycle 0), gnt (0), rvalid (1), instr_valid (2).
- Best-case throughput is one instruction per 3 cycles.
- Wait states on gnt or rvalid stretch REQ or WAIT without limit.
- Redirect acts on the clock edge where it is sampled high. The new request appears at imem_addr in the next cycle, except from FLUSH, which first waits for the stale response.
- instr_valid never depends combinationally on instr_ready or redirect.

## Test plan
- Reset release, RESET_PC=0, memory returning 0x00500093 with 0-wait gnt/rvalid and instr_ready=1 → addresses 0x0, 0x4, 0x8 issued; instr_valid high every 3rd cycle; imm_field=25'h00A0_01.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD → instr, instr_pc and imm_field unchanged; imem_req=0; pc advances to +4 only after ready.
- Branch redirect in HOLD with redirect_pc=0x100, imm_ext=0xFFFF_FFF0, instr_ready=1 in the same cycle → next imem_addr=0x0F0; held instruction not consumed.
- Redirect during WAIT with rvalid delayed 3 cycles → FLUSH; stale data never reaches instr_valid; next request goes to the target.
- JALR redirect, jalr_target=0x0000_2003 → imem_addr=0x2000 and misaligned pulses for 1 cycle. Separately, jalr_target=0x2001 → 0x2000 with no pulse.
- Wrap: pc=0xFFFF_FFFC consumed → next imem_addr=0x0000_0000. Reset pulse during WAIT → imem_req=0 and instr_valid=0 immediately; refetch from RESET_PC.
